shift_right_seq: RTL
====================

# shift_right_seq

Multi-cycle right-shift unit for the MIPS datapath, the counterpart of the combinational left-shift-by-2 used for branch offsets. It performs logical (SRL/SRLV) or arithmetic (SRA/SRAV) right shifts by a variable amount. It retires two bit positions per clock, with one final single-bit step for odd amounts. It sits beside the ALU and uses a start/busy/done handshake so the controller can stall while it works.

## Interface
- WIDTH, 32, operand width in bits.
- SW, 5, shift-amount width; equals log2(WIDTH).
- Clk  input  1  clock; all state changes on the rising edge.
- Rst  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- in  input  WIDTH  operand, captured on the accepting edge.
- shamt  input  SW  shift amount, 0..WIDTH-1, captured with in.
- arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill); captured with in.
- out  output  WIDTH  result register.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse when out holds the final result.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- Internal registers:
  - work[WIDTH-1:0], which drives out directly.
  - cnt[SW-1:0], the remaining shift amount.
  - fill, the captured arith bit ANDed with in[WIDTH-1].
- IDLE with start=1:
  - work <= in, cnt <= shamt, fill <= arith & in[WIDTH-1].
  - Next state is DONE if shamt==0, otherwise SHIFT.
- IDLE with start=0: hold all registers.
- SHIFT:
  - If cnt>=2: work <= {fill,fill,work[WIDTH-1:2]}, cnt <= cnt-2.
  - If cnt==1: work <= {fill,work[WIDTH-1:1]}, cnt <= 0.
  - Go to DONE when the new cnt==0, otherwise stay in SHIFT.
- DONE: done=1 for exactly this cycle; next state is IDLE unconditionally.
- start is ignored whenever busy=1, i.e. in SHIFT and in DONE. It is not queued. A start held high through DONE is accepted on the first IDLE cycle.
- out holds its value in IDLE until the next accepted start. After that edge, out shows the raw captured operand and then the intermediate values.
- Consumers must read out only when done=1, or in IDLE after a done.
- Changes on in, shamt or arith after capture have no effect on the operation in flight.
- Reset: Rst low forces state=IDLE, work=0, cnt=0, fill=0, so out=0, busy=0, done=0, immediately and independent of Clk.
- Reset mid-operation aborts the shift with no done pulse. The first start after Rst deasserts behaves as from power-up.

## Timing
- Let E0 be the rising edge on which start is accepted in IDLE.
- Total latency is L = 1 + ceil(shamt/2) edges from E0 to entry into DONE. done is high during the cycle after edge E0+L-1.
  - shamt=0: done is high in the cycle after E0 (L=1).
  - shamt=1: L=2. shamt=5: L=4. shamt=31: L=17.
- busy rises after E0 and falls after the edge that leaves DONE. The next start can be accepted at the edge ending the first IDLE cycle.
- Back-to-back throughput is therefore L+1 edges per operation.
- No combinational path from any input to out, busy or done. All outputs are registered or decoded from state only.

## Test plan
- Reset: drive Rst=0 with random inputs, then release -> out=0x00000000, busy=0, done=0. Hold start=0 for 10 cycles -> still idle.
- Logical: in=0xF0000000, shamt=4, arith=0 -> done after 3 edges, out=0x0F000000; busy high for exactly 3 cycles.
- Arithmetic, odd amount: in=0x80000000, shamt=31, arith=1 -> done after 17 edges, out=0xFFFFFFFF. Repeat with arith=0 -> out=0x00000001.
- Zero shift and positive sign: in=0x7FFFFFFF, shamt=0, arith=1 -> done in the cycle after E0, out=0x7FFFFFFF.
- Ignored start and operand isolation:
  - Accept in=0x12345678, shamt=8, arith=0.
  - During SHIFT, pulse start with in=0xFFFFFFFF and change shamt.
  - Expected: a single done, out=0x00123456, no second operation.
- Reset mid-operation: start in=0xAAAAAAAA, shamt=20, assert Rst at the 3rd SHIFT cycle -> outputs go to 0 asynchronously and no done occurs. A new start with in=0x00000100, shamt=8 -> out=0x00000001 after 5 edges.

Source files
------------

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter (logical/arithmetic) retiring two bits per clock,
// with a start/busy/done handshake so the controller can stall on it.
module shift_right_seq #(
  parameter int WIDTH = 32,
  parameter int SW    = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [SW-1:0]    shamt,
  input  logic             arith,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  work;
  logic [SW-1:0]     cnt;
  logic [SW-1:0]     cnt_nxt;
  logic              fill;

  function automatic logic [WIDTH-1:0] shr2(input logic [WIDTH-1:0] v, input logic f);
    return {f, f, v[WIDTH-1:2]};
  endfunction

  function automatic logic [WIDTH-1:0] shr1(input logic [WIDTH-1:0] v, input logic f);
    return {f, v[WIDTH-1:1]};
  endfunction

  // Remaining amount after this SHIFT step; a final odd bit collapses to zero.
  always_comb begin
    cnt_nxt = '0;
    if (cnt >= SW'(2))
      cnt_nxt = cnt - SW'(2);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start)
          state_nxt = (shamt == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (cnt_nxt == '0)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Datapath: capture on the accepting edge, then shift by 2 (or 1 for the odd tail).
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      work <= '0;
      cnt  <= '0;
      fill <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work <= in;
            cnt  <= shamt;
            fill <= arith & in[WIDTH-1];
          end
        end
        SHIFT: begin
          if (cnt >= SW'(2))
            work <= shr2(work, fill);
          else
            work <= shr1(work, fill);
          cnt <= cnt_nxt;
        end
        default: ;
      endcase
    end
  end

  assign out  = work;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
